// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_pkg
// Description : Shared CDB packet type and functional-unit grant positions.
// Revision    : 1.0 - initial release
// ============================================================================

package cdb_arbiter_pkg;

  localparam int NUM_FU_DEFAULT = 4;

  // Grant bit positions agreed between the core top and the FUs.
  localparam int FU_ALU = 0;
  localparam int FU_MUL = 1;
  localparam int FU_DIV = 2;
  localparam int FU_LSU = 3;

  localparam int c_tag_w  = 4;
  localparam int c_data_w = 32;

  typedef struct packed {
    logic                valid;
    logic [c_tag_w-1:0]  tag;
    logic [c_data_w-1:0] data;
  } cdb_packet_s;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker over a doubled request vector.
// Revision    : 1.0 - initial release
// ============================================================================

module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] winner_o,
  output logic          any_o
);

  localparam int IW = $clog2(2 * N);

  logic [2*N-1:0] w_req2;
  logic [IW-1:0]  w_idx;
  logic [PW-1:0]  w_win;
  logic           w_hit;

  assign w_req2 = {req_i, req_i};

  // Scan from the far end back toward ptr so the closest requester is kept.
  always_comb begin
    w_win = '0;
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = IW'(ptr_i) + IW'(k);
      if (w_req2[w_idx]) begin
        w_hit = 1'b1;
        w_win = (w_idx >= IW'(N)) ? PW'(w_idx - IW'(N)) : PW'(w_idx);
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (w_hit) begin
      grant_o[w_win] = 1'b1;
    end
  end

  assign winner_o = w_win;
  assign any_o    = w_hit;

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Round-robin CDB arbiter with registered broadcast and counter.
// Revision    : 1.0 - initial release
// ============================================================================

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEFAULT
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  cdb_packet_s       fu_result_i [NUM_FU],
  output logic [NUM_FU-1:0] cdb_grant_o,
  output cdb_packet_s       cdb_o,
  output logic [31:0]       grant_count_o
);

  localparam int PW = $clog2(NUM_FU);

  logic [NUM_FU-1:0] w_req;
  logic [NUM_FU-1:0] w_pick_grant;
  logic [PW-1:0]     w_winner;
  logic [PW-1:0]     w_ptr_next;
  logic              w_any;
  logic              w_grant_en;
  cdb_packet_s       w_win_pkt;

  logic [PW-1:0]     r_ptr;
  cdb_packet_s       r_cdb;
  logic [31:0]       r_count;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_req
    assign w_req[i] = fu_result_i[i].valid;
  end

  rr_pick #(
    .N  (NUM_FU),
    .PW (PW)
  ) u_rr_pick (
    .req_i    (w_req),
    .ptr_i    (r_ptr),
    .grant_o  (w_pick_grant),
    .winner_o (w_winner),
    .any_o    (w_any)
  );

  // Grant depends only on requests, pointer, flush and reset - never on itself.
  assign w_grant_en  = w_any & ~flush_i & ~reset_i;
  assign cdb_grant_o = w_grant_en ? w_pick_grant : '0;

  assign w_ptr_next = (w_winner == PW'(NUM_FU - 1)) ? '0 : w_winner + PW'(1);

  always_comb begin
    w_win_pkt       = fu_result_i[w_winner];
    w_win_pkt.valid = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr   <= '0;
      r_cdb   <= '0;
      r_count <= '0;
    end else if (w_grant_en) begin
      r_ptr <= w_ptr_next;
      r_cdb <= w_win_pkt;
      if (r_count != 32'hFFFF_FFFF) begin
        r_count <= r_count + 32'd1;
      end
    end else begin
      // Idle and flush cycles broadcast an all-zero packet, never stale data.
      r_cdb <= '0;
    end
  end

  assign cdb_o         = r_cdb;
  assign grant_count_o = r_count;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Scoreboard bench for cdb_arbiter with a reference round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  cdb_packet_s fu [4];
  logic [3:0]  grant;
  cdb_packet_s cdb;
  logic [31:0] count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_ptr = 0;
  int          m_count = 0;
  cdb_packet_s exp_q [$];

  cdb_arbiter #(.NUM_FU(4)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .flush_i       (flush),
    .fu_result_i   (fu),
    .cdb_grant_o   (grant),
    .cdb_o         (cdb),
    .grant_count_o (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle: check the combinational grant, push the expected broadcast,
  // cross the clock edge, then pop and compare the registered output.
  task automatic step(output logic [3:0] g_seen);
    logic [3:0]  eg;
    int          w;
    cdb_packet_s ep;
    #1;
    eg = '0;
    w  = -1;
    if (!reset && !flush) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (w < 0 && fu[idx].valid) w = idx;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    g_seen = grant;
    chk("grant", 64'(grant), 64'(eg));
    ep = '0;
    if (w >= 0) begin
      ep       = fu[w];
      ep.valid = 1'b1;
    end
    exp_q.push_back(ep);
    if (reset) begin
      m_ptr   = 0;
      m_count = 0;
    end else if (w >= 0) begin
      m_ptr   = (w + 1) % 4;
      m_count = m_count + 1;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 64'd1, 64'd0);
    end else begin
      chk("cdb", 64'(cdb), 64'(exp_q.pop_front()));
    end
    chk("count", 64'(count), 64'(m_count));
  endtask

  task automatic set_fu(input int i, input logic v, input logic [3:0] t, input logic [31:0] d);
    fu[i].valid = v;
    fu[i].tag   = t;
    fu[i].data  = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) set_fu(i, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  g;
    logic [3:0]  dropped;
    logic [31:0] saved;

    flush = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 4'(i + 8), 32'h100 + 32'(i));

    // Reset held with all FUs requesting.
    for (int c = 0; c < 2; c++) begin
      step(g);
      chk("rst_grant", 64'(g), 64'd0);
      chk("rst_valid", 64'(cdb.valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
    end
    reset = 1'b0;
    clear_all();

    // Single divider request.
    set_fu(FU_DIV, 1'b1, 4'h5, 32'h0000_0007);
    step(g);
    chk("single_grant", 64'(g), 64'b0100);
    chk("single_valid", 64'(cdb.valid), 64'd1);
    chk("single_tag", 64'(cdb.tag), 64'h5);
    chk("single_data", 64'(cdb.data), 64'h7);
    clear_all();

    // Wrap-around from ptr=3.
    set_fu(1, 1'b1, 4'h1, 32'hAAAA_0001);
    set_fu(3, 1'b1, 4'h3, 32'hAAAA_0003);
    step(g);
    chk("wrap_fu3", 64'(g), 64'b1000);
    set_fu(3, 1'b0, 4'h0, 32'h0);
    step(g);
    chk("wrap_fu1", 64'(g), 64'b0010);
    clear_all();
    set_fu(0, 1'b1, 4'h0, 32'h10);
    set_fu(2, 1'b1, 4'h2, 32'h12);
    set_fu(3, 1'b1, 4'h3, 32'h13);
    step(g);
    chk("ptr_is_2", 64'(g), 64'b0100);
    clear_all();
    set_fu(3, 1'b1, 4'h3, 32'h33);
    step(g);
    chk("ptr_to_0", 64'(g), 64'b1000);

    // Fairness with drop/re-assert.
    for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 4'(i), 32'hF000 + 32'(i));
    saved   = count;
    dropped = '0;
    for (int c = 0; c < 8; c++) begin
      step(g);
      chk("fair_order", 64'(g), 64'(4'b0001 << (c % 4)));
      for (int i = 0; i < 4; i++) if (dropped[i]) fu[i].valid = 1'b1;
      dropped = g;
      for (int i = 0; i < 4; i++) if (g[i]) fu[i].valid = 1'b0;
    end
    chk("fair_count", 64'(count - saved), 64'd8);
    clear_all();

    // Flush suppresses the grant and leaves the pointer alone.
    set_fu(1, 1'b1, 4'h9, 32'h99);
    step(g);
    clear_all();
    set_fu(0, 1'b1, 4'hC, 32'hC0DE);
    flush = 1'b1;
    step(g);
    chk("flush_grant", 64'(g), 64'd0);
    chk("flush_valid", 64'(cdb.valid), 64'd0);
    flush = 1'b0;
    step(g);
    chk("post_flush", 64'(g), 64'b0001);
    clear_all();

    // Idle gap.
    saved = count;
    for (int c = 0; c < 3; c++) begin
      step(g);
      chk("idle_cdb", 64'(cdb), 64'd0);
      chk("idle_count", 64'(count), 64'(saved));
    end

    // Reset mid-stream drops the in-flight broadcast.
    for (int i = 0; i < 4; i++) set_fu(i, 1'b1, 4'(i + 4), 32'hBEEF + 32'(i));
    step(g);
    reset = 1'b1;
    step(g);
    chk("mid_rst_grant", 64'(g), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    reset = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 4; i++)
        set_fu(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      flush = ($urandom_range(0, 7) == 0);
      step(g);
    end
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
